// File: rtl/data_ram_pkg.sv
// rtl/data_ram_pkg.sv - access-size encodings and FSM state type for data_ram
package data_ram_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/data_ram_align.sv
// rtl/data_ram_align.sv - byte-lane mask, store data replication, misalign flag and load formatter
module data_ram_align
  import data_ram_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_i,
  input  logic        sign_ext_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] raw_word_i,
  output logic [3:0]  wmask_o,
  output logic [31:0] wdata_o,
  output logic        misalign_o,
  output logic [31:0] load_data_o
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign lane_b = raw_word_i[{addr_i, 3'b000} +: 8];
  assign lane_h = addr_i[1] ? raw_word_i[31:16] : raw_word_i[15:0];

  // Misaligned or reserved accesses leave the mask empty and hand back the raw word.
  always_comb begin
    misalign_o  = 1'b0;
    wmask_o     = 4'b0000;
    wdata_o     = store_data_i;
    load_data_o = raw_word_i;
    case (size_i)
      SZ_BYTE: begin
        wmask_o     = 4'b0001 << addr_i;
        wdata_o     = {4{store_data_i[7:0]}};
        load_data_o = {{24{sign_ext_i & lane_b[7]}}, lane_b};
      end
      SZ_HALF: begin
        if (addr_i[0]) begin
          misalign_o = 1'b1;
        end else begin
          wmask_o     = addr_i[1] ? 4'b1100 : 4'b0011;
          wdata_o     = {2{store_data_i[15:0]}};
          load_data_o = {{16{sign_ext_i & lane_h[15]}}, lane_h};
        end
      end
      SZ_WORD: begin
        if (addr_i != 2'b00) misalign_o = 1'b1;
        else                 wmask_o    = 4'b1111;
      end
      default: misalign_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/data_ram.sv
// rtl/data_ram.sv - parametrised CPU data RAM with sub-word access and sequential clear sweep
// Optional debug read port: define DATA_RAM_DEBUG_PORT_EN
module data_ram
  import data_ram_pkg::*;
#(
  parameter int DEPTH        = 1024,
  parameter int ADDR_W       = 12,
  parameter int CLR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              clr_req,
  input  logic              str,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       datain,
  output logic [31:0]       dataout,
  output logic              misalign,
  output logic              busy
`ifdef DATA_RAM_DEBUG_PORT_EN
  ,
  input  logic [ADDR_W-1:0] debug_address,
  output logic [31:0]       debug_dataout
`endif
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

  logic [31:0]      mem_q [DEPTH];
  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;

  logic [IDX_W-1:0] idx;
  logic [31:0]      raw_word, load_data, st_data;
  logic [3:0]       st_mask;
  logic             mis_raw;

  logic             mem_we;
  logic [IDX_W-1:0] mem_addr;
  logic [31:0]      mem_wdata;
  logic [3:0]       mem_mask;

  logic             unused_addr;

  // Upper address bits are ignored so accesses wrap modulo DEPTH words.
  assign idx         = address[IDX_W+1:2];
  assign unused_addr = ^(address >> (IDX_W + 2));
  assign raw_word    = mem_q[idx];

  data_ram_align u_align (
    .size_i      (size),
    .addr_i      (address[1:0]),
    .sign_ext_i  (sign_ext),
    .store_data_i(datain),
    .raw_word_i  (raw_word),
    .wmask_o     (st_mask),
    .wdata_o     (st_data),
    .misalign_o  (mis_raw),
    .load_data_o (load_data)
  );

  assign busy     = (state_q == CLEAR);
  assign misalign = mis_raw & ~busy;
  assign dataout  = busy ? 32'h0 : load_data;

  // One write port shared by CPU stores and the sweep; a clear request beats a same-cycle store.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    mem_we    = 1'b0;
    mem_addr  = idx;
    mem_wdata = st_data;
    mem_mask  = st_mask;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end else if (str && !mis_raw) begin
          mem_we = 1'b1;
        end
      end
      CLEAR: begin
        mem_we    = 1'b1;
        mem_addr  = ptr_q;
        mem_wdata = 32'h0;
        mem_mask  = 4'b1111;
        ptr_d     = ptr_q + 1'b1;
        if (ptr_q == LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q <= (CLR_ON_RESET != 0) ? CLEAR : IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Reset never touches the array directly; only the sweep clears it.
  always_ff @(posedge clk) begin
    if (clr_n && mem_we) begin
      for (int n = 0; n < 4; n++) begin
        if (mem_mask[n]) mem_q[mem_addr][8*n +: 8] <= mem_wdata[8*n +: 8];
      end
    end
  end

`ifdef DATA_RAM_DEBUG_PORT_EN
  logic unused_dbg;
  assign unused_dbg    = ^{debug_address[1:0], debug_address >> (IDX_W + 2)};
  assign debug_dataout = mem_q[debug_address[IDX_W+1:2]];
`endif

endmodule
